// File: rtl/xorshift_stream_checker_pkg.sv
// Shared constants, state encoding and the xorshift step functions used by
// the stream checker (and by anything that generates or models the stream).
package xorshift_stream_checker_pkg;

    localparam int unsigned WORDS   = 256;
    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned ERR_W   = 9;
    localparam int unsigned GAP_W   = $clog2(TIMEOUT + 1);

    localparam logic [ERR_W-1:0] WORDS_C   = ERR_W'(WORDS);
    localparam logic [GAP_W-1:0] TIMEOUT_C = GAP_W'(TIMEOUT);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // One forward xorshift step: x ^= x<<13; x ^= x>>17; x ^= x<<5.
    function automatic logic [31:0] xorshift_fwd(input logic [31:0] s);
        logic [31:0] x;
        x = s ^ (s << 5'd13);
        x = x ^ (x >> 5'd17);
        x = x ^ (x << 5'd5);
        return x;
    endfunction

    // Exact inverse of xorshift_fwd, undoing the three xor-shifts in reverse.
    function automatic logic [31:0] xorshift_inv(input logic [31:0] y);
        logic [31:0] x;
        x = y ^ (y << 5'd5) ^ (y << 5'd10) ^ (y << 5'd15)
              ^ (y << 5'd20) ^ (y << 5'd25) ^ (y << 5'd30);
        x = x ^ (x >> 5'd17);
        x = x ^ (x << 5'd13) ^ (x << 5'd26);
        return x;
    endfunction

endpackage

// File: rtl/xorshift_stream_checker_if.sv
// Stream input and frame report bundle of the xorshift stream checker.
interface xorshift_stream_checker_if;
    import xorshift_stream_checker_pkg::*;

    logic             in_valid;
    logic [31:0]      rand_num;
    logic             out_valid;
    logic [31:0]      seed_out;
    logic [ERR_W-1:0] word_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic             timeout;

    modport master (
        output in_valid, rand_num,
        input  out_valid, seed_out, word_cnt, err_cnt, timeout
    );

    modport slave (
        input  in_valid, rand_num,
        output out_valid, seed_out, word_cnt, err_cnt, timeout
    );
endinterface

// File: rtl/xorshift_stream_checker.sv
// Receiver-side checker for a framed 32-bit xorshift stream: recovers the
// seed from word 0, predicts the rest of the frame, counts mismatches and
// emits a one-cycle report per frame (full frame or gap timeout).
module xorshift_stream_checker
    import xorshift_stream_checker_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    xorshift_stream_checker_if.slave  bus
);

    state_t           state_r, state_s;
    logic [31:0]      seed_rec_r, seed_rec_s;
    logic [31:0]      expect_r, expect_s;
    logic [ERR_W-1:0] cnt_r, cnt_s;
    logic [ERR_W-1:0] errs_r, errs_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic             report_s;
    logic             timeout_s;

    logic             out_valid_r;
    logic [31:0]      seed_out_r;
    logic [ERR_W-1:0] word_cnt_r;
    logic [ERR_W-1:0] err_cnt_r;
    logic             timeout_r;

    // Next-state and datapath update; the prediction chain advances from
    // the predicted word, so a single corrupted word costs a single error.
    always_comb begin
        state_s    = state_r;
        seed_rec_s = seed_rec_r;
        expect_s   = expect_r;
        cnt_s      = cnt_r;
        errs_s     = errs_r;
        gap_s      = gap_r;
        report_s   = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE, REPORT: begin
                if (bus.in_valid) begin
                    seed_rec_s = xorshift_inv(bus.rand_num);
                    expect_s   = xorshift_fwd(bus.rand_num);
                    cnt_s      = {{(ERR_W-1){1'b0}}, 1'b1};
                    errs_s     = {ERR_W{1'b0}};
                    gap_s      = {GAP_W{1'b0}};
                    state_s    = RUN;
                end else begin
                    state_s    = IDLE;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    if ((bus.rand_num != expect_r) && (errs_r != ERR_MAX)) begin
                        errs_s = errs_r + {{(ERR_W-1){1'b0}}, 1'b1};
                    end else begin
                        errs_s = errs_r;
                    end
                    expect_s = xorshift_fwd(expect_r);
                    cnt_s    = cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
                    gap_s    = {GAP_W{1'b0}};
                    if (cnt_s == WORDS_C) begin
                        state_s  = REPORT;
                        report_s = 1'b1;
                    end else begin
                        state_s  = RUN;
                    end
                end else begin
                    gap_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
                    if (gap_s == TIMEOUT_C) begin
                        state_s   = REPORT;
                        report_s  = 1'b1;
                        timeout_s = 1'b1;
                    end else begin
                        state_s   = RUN;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered report outputs (zero when not reporting).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            seed_rec_r  <= 32'd0;
            expect_r    <= 32'd0;
            cnt_r       <= {ERR_W{1'b0}};
            errs_r      <= {ERR_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            out_valid_r <= 1'b0;
            seed_out_r  <= 32'd0;
            word_cnt_r  <= {ERR_W{1'b0}};
            err_cnt_r   <= {ERR_W{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            seed_rec_r  <= seed_rec_s;
            expect_r    <= expect_s;
            cnt_r       <= cnt_s;
            errs_r      <= errs_s;
            gap_r       <= gap_s;
            out_valid_r <= report_s;
            seed_out_r  <= report_s ? seed_rec_r : 32'd0;
            word_cnt_r  <= report_s ? cnt_s : {ERR_W{1'b0}};
            err_cnt_r   <= report_s ? errs_s : {ERR_W{1'b0}};
            timeout_r   <= timeout_s;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.seed_out  = seed_out_r;
    assign bus.word_cnt  = word_cnt_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Scoreboard bench for xorshift_stream_checker: the driver builds each frame
// from a known seed with its own xorshift model, injects corruptions, and
// queues the expected report; a monitor compares every report as it appears.
module tb_xorshift_stream_checker;
    import xorshift_stream_checker_pkg::*;

    typedef struct {
        logic [31:0] seed;
        int          wc;
        int          ec;
        logic        to;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    bit   mon_en;
    int   checks;
    int   errors;
    exp_t sb[$];

    xorshift_stream_checker_if bus ();

    xorshift_stream_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference step written straight from the rule x^=x<<13; x^=x>>17; x^=x<<5.
    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] a;
        logic [31:0] b;
        a = v ^ ((v * 32'd8192) & 32'hFFFF_FFFF);
        b = a ^ (a / 32'd131072);
        return b ^ ((b * 32'd32) & 32'hFFFF_FFFF);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare on each report, otherwise outputs must be zero.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_report", 64'(bus.seed_out), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("seed_out", 64'(bus.seed_out), 64'(e.seed));
                    check("word_cnt", 64'(bus.word_cnt), 64'(e.wc));
                    check("err_cnt",  64'(bus.err_cnt),  64'(e.ec));
                    check("timeout",  64'(bus.timeout),  64'(e.to));
                    check("report_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("idle_outputs_zero",
                      64'({bus.seed_out, bus.word_cnt, bus.err_cnt, bus.timeout}), 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Drive n words of the stream for 'seed'; word bad_x is XORed with xmask,
    // word bad_z is replaced by 0 (-1 disables either). Queues the report.
    task automatic send_frame(input logic [31:0] seed, input int n, input int gap_max,
                              input int bad_x, input logic [31:0] xmask,
                              input int bad_z, input bit expect_report);
        logic [31:0] clean;
        logic [31:0] w;
        int          errs;
        int          last_c;
        exp_t        e;
        clean = seed;
        errs  = 0;
        last_c = 0;
        for (int i = 0; i < n; i++) begin
            clean = model_step(clean);
            w = clean;
            if (i == bad_x) w = w ^ xmask;
            if (i == bad_z) w = 32'd0;
            if (i > 0 && w != clean) errs++;
            if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.rand_num = w;
            last_c = cyc;
        end
        if (expect_report) begin
            e.seed = seed;
            e.wc   = n;
            e.ec   = errs;
            e.to   = (n < int'(WORDS));
            e.cyc  = last_c + 1 + (e.to ? int'(TIMEOUT) : 0);
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [31:0] s;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.rand_num = 32'd0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Model sanity and the shared inverse function.
        check("model_f1", 64'(model_step(32'd1)), 64'h0004_2021);
        for (int i = 0; i < 4; i++) begin
            s = $urandom;
            check("inv_of_fwd", 64'(xorshift_inv(xorshift_fwd(s))), 64'(s));
        end

        // Seed 1, back-to-back words.
        send_frame(32'd1, 256, 0, -1, 32'd0, -1, 1'b1);
        idle(4);
        // Seed 0 with random 0-5 cycle gaps.
        send_frame(32'd0, 256, 5, -1, 32'd0, -1, 1'b1);
        idle(3);
        // Corruption: word 10 bit 0 flipped, word 200 zeroed.
        send_frame(32'h1234_5678, 256, 0, 10, 32'h1, 200, 1'b1);
        idle(3);
        // Timeout after 100 words.
        send_frame(32'hCAFE_0001, 100, 0, -1, 32'd0, -1, 1'b1);
        idle(int'(TIMEOUT) + 6);
        // Back-to-back frames: seed 7 word 0 lands on the REPORT cycle.
        send_frame(32'd1, 256, 0, -1, 32'd0, -1, 1'b1);
        send_frame(32'd7, 256, 0, -1, 32'd0, -1, 1'b1);
        idle(3);
        // Reset after word 50 discards the frame.
        send_frame(32'h0BAD_F00D, 51, 0, -1, 32'd0, -1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        send_frame(32'd3, 256, 0, -1, 32'd0, -1, 1'b1);
        idle(3);
        // Randomised frames with random gaps and corruptions.
        for (int k = 0; k < 2; k++) begin
            send_frame($urandom, 256, 3, $urandom_range(1, 255), $urandom | 32'd1,
                       $urandom_range(1, 255), 1'b1);
            idle(2);
        end

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        check("all_reports_seen", 64'(sb.size()), 64'd0);
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit actual=%0d required=finished", cyc);
        $fatal(1, "time limit");
    end

endmodule
